// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
package uart_pkg;

  localparam int   UART_DATA_BITS       = 8;
  localparam int   UART_DEFAULT_CLK_DIV = 16;
  localparam logic UART_IDLE_LEVEL      = 1'b1;

  // Transmit state encoding; PARITY only exists in parity builds.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam uart_state_t ST_PARITY = 3'd3;
`endif
  localparam uart_state_t ST_STOP   = 3'd4;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with show-ahead read (dout is the current head).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  // Full blocks pushes even if a pop happens in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; wrap is implicit in the AW+1 bit width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte intake into a FIFO, serialised
// LSB first as 8N1 frames with no idle gap between queued frames.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even parity).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);
  localparam int             BW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_t            state;
  logic [CW-1:0]          baud_cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   baud_end;
  logic                   tx_next;
`ifdef UART_TX_PARITY_EN
  logic                   par_bit;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state != ST_IDLE);
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Pop from IDLE, or straight out of the final stop cycle so the next
  // start bit follows without an idle cycle.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

  // Frame sequencing: state, baud counter and bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (fifo_pop) state <= ST_START;
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= fifo_empty ? ST_IDLE : ST_START;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // Shift register: load on pop, shift right at the end of each data bit.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift_reg <= fifo_dout;
    end else if ((state == ST_DATA) && baud_end) begin
      shift_reg <= shift_reg >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at load time because the shift register is consumed.
  always_ff @(posedge clk) begin
    if (fifo_pop) par_bit <= even_parity(fifo_dout);
  end
`endif

  // Line level implied by the current state.
  always_comb begin
    tx_next = UART_IDLE_LEVEL;
    case (state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_bit;
`endif
      ST_STOP:   tx_next = 1'b1;
      default:   tx_next = UART_IDLE_LEVEL;
    endcase
  end

  // Registered line and done pulse; done marks the last stop-bit cycle on tx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx      <= UART_IDLE_LEVEL;
      tx_done <= 1'b0;
    end else begin
      tx      <= tx_next;
      tx_done <= (state == ST_STOP) && baud_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (CLK_DIV=4, FIFO_DEPTH=4) with a
// bench-side serial receiver that decodes frames from tx.
module tb_uart_tx_buffered;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_level;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       rx_en = 1'b0;

  uart_tx_buffered #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_BITS  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot i of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0)              return 1'b0;
    else if (i <= 8)         return b[i-1];
    else if (i == NBITS - 1) return 1'b1;
    else                     return ^b;
  endfunction

  // tx_done pulse recorder.
  always begin
    @(posedge clk);
    #1;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_q.push_back(cyc);
    end
  end

  // Serial receiver: mid-bit sampling from the first low cycle.
  always begin
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (rx_en && tx === 1'b0) begin
      repeat (CLK_DIV / 2) step();
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) step();
        b[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CLK_DIV) step();
      check("rx_parity", tx, ^b);
`endif
      repeat (CLK_DIV) step();
      check("rx_stop", tx, 1);
      rx_q.push_back(b);
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || fifo_level !== 3'd0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_idle_in_time"}, (n < budget), 1);
    repeat (3) step();
  endtask

  task automatic drain_rx(input string tag);
    int n = 0;
    int i = 0;
    while (rx_q.size() < exp_q.size() && n < 2 * FRAME) begin
      step();
      n++;
    end
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check($sformatf("%s_rx[%0d]", tag, i), rx_q.pop_front(), exp_q.pop_front());
      i++;
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // Push one byte from idle and check the whole frame cycle by cycle.
  task automatic send_frame(input logic [7:0] b, input string tag);
    int d0;
    d0 = done_cnt;
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    step();
    tx_valid = 1'b0;
    tx_data  = 8'hC3;
    check({tag, "_e0_tx"}, tx, 1);
    check({tag, "_e0_level"}, fifo_level, 1);
    step();
    check({tag, "_e1_tx"}, tx, 1);
    check({tag, "_e1_busy"}, tx_busy, 1);
    check({tag, "_e1_level"}, fifo_level, 0);
    step();
    for (int k = 0; k < FRAME; k++) begin
      check($sformatf("%s_tx[%0d]", tag, k), tx, frame_bit(b, k / CLK_DIV));
      check($sformatf("%s_done[%0d]", tag, k), tx_done, (k == FRAME - 1));
      if (k < FRAME - 1) step();
    end
    step();
    check({tag, "_after_tx"}, tx, 1);
    check({tag, "_after_busy"}, tx_busy, 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    drain_rx(tag);
  endtask

  initial begin
    logic [7:0] bb [5];
    int d0;
    int q0;
    int acc;
    int last_acc;
    int n;
    int lows;

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    reset    = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    step();
    rx_en = 1'b1;

    // Single byte
    send_frame(8'hA5, "single");

    // Back-to-back
    d0 = done_cnt;
    q0 = done_q.size();
    bb = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = bb[i];
      exp_q.push_back(bb[i]);
      step();
      check($sformatf("b2b_level[%0d]", i), fifo_level, (i == 0) ? 1 : i);
      check($sformatf("b2b_ready[%0d]", i), tx_ready, (i < 4) ? 1 : 0);
    end
    tx_valid = 1'b0;
    wait_idle("b2b", 6 * FRAME + 20);
    check("b2b_done_count", done_cnt - d0, 5);
    for (int i = 1; i < 5; i++) begin
      if (done_q.size() > q0 + i)
        check($sformatf("b2b_done_gap[%0d]", i), done_q[q0+i] - done_q[q0+i-1], FRAME);
    end
    drain_rx("b2b");

    // Full boundary: hold 0x3C while full
    bb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = bb[i];
      exp_q.push_back(bb[i]);
      step();
    end
    check("full_level", fifo_level, 4);
    check("full_ready", tx_ready, 0);
    tx_data  = 8'h3C;
    acc      = 0;
    last_acc = 0;
    n        = 0;
    while (acc < 3 && n < 5 * FRAME) begin
      if (tx_ready === 1'b1) begin
        acc++;
        exp_q.push_back(8'h3C);
        check($sformatf("full_level_at_ready[%0d]", acc), fifo_level, 3);
        if (acc > 1) check($sformatf("full_slot_gap[%0d]", acc), cyc - last_acc, FRAME);
        last_acc = cyc;
        step();
        n++;
        check($sformatf("full_ready_after_push[%0d]", acc), tx_ready, 0);
        check($sformatf("full_level_after_push[%0d]", acc), fifo_level, 4);
      end else begin
        step();
        n++;
      end
    end
    tx_valid = 1'b0;
    check("full_accepts", acc, 3);
    wait_idle("full", 8 * FRAME);
    drain_rx("full");

    // Reset mid-frame during DATA bit 3 of 0x81 with two bytes queued
    rx_en = 1'b0;
    d0 = done_cnt;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    step();
    tx_data  = 8'h12;
    step();
    tx_data  = 8'h34;
    step();
    tx_valid = 1'b0;
    check("mid_level", fifo_level, 2);
    check("mid_start_tx", tx, 0);
    repeat (17) step();
    check("mid_bit3_tx", tx, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_done", tx_done, 0);
    repeat (2) step();
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("mid_line_idle", lows, 0);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_level_after", fifo_level, 0);
    rx_en = 1'b1;
    send_frame(8'h5A, "post_rst");

    // Sweep 0..255 then 255..0
    d0 = done_cnt;
    for (int v = 0; v < 512; v++) begin
      n = 0;
      while (tx_ready !== 1'b1 && n < 2 * FRAME) begin
        step();
        n++;
      end
      if (n >= 2 * FRAME) check("sweep_ready_timeout", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = (v < 256) ? 8'(v) : 8'(511 - v);
      exp_q.push_back(tx_data);
      step();
      tx_valid = 1'b0;
    end
    wait_idle("sweep", 6 * FRAME);
    drain_rx("sweep");
    check("sweep_done_count", done_cnt - d0, 512);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has parity 1, 0x03 has parity 0
    send_frame(8'h07, "par07");
    send_frame(8'h03, "par03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered UART transmitter. It accepts bytes from a host over a valid/ready handshake and queues them in a small synchronous FIFO. It serialises them onto `tx` as 8N1 frames (optionally 8E1), LSB first, with no idle gap between queued frames. It is the stand-alone transmit end of the UART link and is intended to drive the `rx` pin of `uart_core` and the Avalon UART slave.

Parameters:
- CLK_DIV, 16, clock cycles per bit period; legal values are 2 or more.
- FIFO_DEPTH, 4, number of queued bytes; must be a power of 2 and at least 2.
- DATA_BITS, 8, data bits per frame; fixed at 8 in this release.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  host asserts this when tx_data holds a byte.
- tx_data  in  8  byte to transmit; sampled only on handshake.
- tx_ready  out  1  FIFO not full; a byte is accepted when tx_valid && tx_ready.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is on the line (START through STOP).
- tx_done  out  1  one-cycle pulse on the last cycle of each stop bit.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte currently shifting.

Behaviour:
- Reset values, applied asynchronously and held while reset=1: tx=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_level=0, state=IDLE, FIFO empty, bit and baud counters 0.
- Handshake: push happens on a clk edge with tx_valid && tx_ready.
  - tx_ready = !full, and depends on FIFO state only (no combinational path from tx_valid).
  - tx_data is ignored whenever no push occurs.
- FIFO: pointers are one bit wider than the address and wrap modulo 2*FIFO_DEPTH.
  - Full when the addresses match and the MSBs differ.
  - Push and pop in the same cycle: level is unchanged and both take effect.
  - When full, ready=0, so a same-cycle pop does not enable a push.
- State machine, with a registered output tx:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, reset the baud counter, go to START. First-byte latency: a push at edge N sets tx=0 after edge N+2.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles, then shift right and increment the bit index. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: only exists when the feature is compiled in (see Optional Feature).
  - STOP: tx=1 for CLK_DIV cycles. tx_done pulses on the final cycle. On that same edge:
    - FIFO non-empty: pop, go to START. The next start bit begins immediately, so there is no extra idle cycle.
    - FIFO empty: go to IDLE.
- Baud counter: counts 0..CLK_DIV-1. The state advances on the edge where the count equals CLK_DIV-1.
- Frame length: 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
- tx_busy = (state != IDLE).
- Reset asserted mid-frame: tx goes high immediately, queued data is discarded, and no tx_done is produced. After reset is released the block starts in IDLE.
- A push while a frame is shifting only enqueues. It never corrupts the frame in flight.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and drives the even-parity bit (^byte) for CLK_DIV cycles.
  - Frame is 11 bits (8E1).
- Undefined:
  - No PARITY state and no parity logic; frame is 8N1.
  - The state encoding omits PARITY.

Decomposition:
- Package uart_pkg holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_BITS=8;
  - UART_DEFAULT_CLK_DIV=16;
  - UART_IDLE_LEVEL=1'b1.
- One sub-module, uart_sync_fifo, parameterised by WIDTH and DEPTH. It provides push, pop, dout, full, empty and level. The top-level holds the FSM, baud counter and shift register.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Single byte: push 0xA5 while idle -> tx low after edge 2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. tx_done pulses once, 40 cycles after the start bit begins. A loopback `uart_core` rx returns 165.
- Back-to-back: push 0x00,0xFF,0x55,0xAA,0x0F on consecutive cycles -> tx_ready drops after the 5th push (1 byte shifting + 4 queued) and fifo_level peaks at 4. Five frames go out with zero idle cycles between stop and start bits. Five tx_done pulses arrive 40 cycles apart.
- Full boundary: hold tx_valid with tx_data=0x3C while full -> no push until the STOP-to-START pop. tx_ready returns the cycle after that pop, and exactly one 0x3C is accepted per freed slot.
- Reset mid-frame: assert reset during DATA bit 3 of 0x81 with 2 bytes queued -> tx=1 immediately, fifo_level=0, no tx_done. After release, the line stays idle until a new push.
- Sweep: push 0..255, then 255..0, into loopback `uart_core` -> all 512 rx_data values match and the tx_done count is 512.
- With UART_TX_PARITY_EN: push 0x07 -> parity bit is 1 and the frame is 44 cycles long. Push 0x03 -> parity bit is 0.
